layer_sequencer: RTL and testbench

//  Fetches layer/control descriptors from a program memory and executes them in order.

---
 rtl/layer_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
//   Fetches descriptors from program memory and runs them in order. LAYER
//   descriptors go to the NN compute core over a valid/ready handshake, and
//   the sequencer then waits for the core's done pulse. RESET pulses the
//   accumulator clear. JUMP redirects the program counter. HALT ends the
//   program. Opcodes 4-7 are illegal: they raise a sticky error and end the
//   program.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   run, continuous     host status bits: start/keep running, loop program
//   start_addr          first descriptor address
//   mem_rd_en/mem_addr  program memory read port (data valid next cycle)
//   mem_rdata           descriptor word
//   layer_valid/ready   descriptor handshake to the compute core
//   layer_*             registered descriptor fields, stable while valid
//   layer_done          core finished the accepted layer (1-cycle pulse)
//   acc_reset           1-cycle accumulator clear pulse
//   busy, done, error   status: not idle / program-end pulse / sticky error
//
// Optional feature: define LAYER_SEQ_PERF_CNT_EN to add perf_layers
// (layers accepted) and perf_stall (cycles layer_valid & !layer_ready).
// Both counters saturate and clear on reset and on program start.
// ---------------------------------------------------------------------------
module layer_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int X_OFF_W = 11,
  parameter int W_OFF_W = 12,
  parameter int Y_OFF_W = 11,
  parameter int LEN_W   = 12,
  parameter int ACT_W   = 4,
  localparam int INST_W = 3 + 1 + X_OFF_W + W_OFF_W + 1 + Y_OFF_W + 2*LEN_W + ACT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               continuous,
  input  logic [ADDR_W-1:0]  start_addr,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INST_W-1:0]  mem_rdata,
  output logic               layer_valid,
  input  logic               layer_ready,
  output logic               layer_reset,
  output logic [X_OFF_W-1:0] layer_x_offset,
  output logic [W_OFF_W-1:0] layer_w_offset,
  output logic               layer_output_layer,
  output logic [Y_OFF_W-1:0] layer_y_offset,
  output logic [LEN_W-1:0]   layer_x_length,
  output logic [LEN_W-1:0]   layer_y_length,
  output logic [ACT_W-1:0]   layer_act_mask,
  input  logic               layer_done,
  output logic               acc_reset,
  output logic               busy,
  output logic               done,
  output logic               error
`ifdef LAYER_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_layers,
  output logic [31:0]        perf_stall
`endif
);

  // Field positions, LSB upwards.
  localparam int ACT_LSB  = 0;
  localparam int YLEN_LSB = ACT_LSB + ACT_W;
  localparam int XLEN_LSB = YLEN_LSB + LEN_W;
  localparam int YOFF_LSB = XLEN_LSB + LEN_W;
  localparam int OUT_BIT  = YOFF_LSB + Y_OFF_W;
  localparam int WOFF_LSB = OUT_BIT + 1;
  localparam int XOFF_LSB = WOFF_LSB + W_OFF_W;
  localparam int RST_BIT  = XOFF_LSB + X_OFF_W;
  localparam int OP_LSB   = RST_BIT + 1;
  localparam int DESC_W   = OP_LSB;  // everything below the opcode

  localparam logic [2:0] OP_HALT  = 3'd0;
  localparam logic [2:0] OP_LAYER = 3'd1;
  localparam logic [2:0] OP_RESET = 3'd2;
  localparam logic [2:0] OP_JUMP  = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_BUSY   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [DESC_W-1:0]   desc_q, desc_d;
  logic                acc_reset_q, acc_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [2:0]          opcode;

  assign opcode = mem_rdata[OP_LSB +: 3];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    desc_d      = desc_q;
    acc_reset_d = 1'b0;
    done_d      = 1'b0;
    error_d     = error_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          pc_d    = start_addr;
          error_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LAYER: begin
            desc_d  = mem_rdata[DESC_W-1:0];
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end
          OP_RESET, OP_JUMP: begin
            acc_reset_d = (opcode == OP_RESET);
            pc_d = (opcode == OP_JUMP) ? mem_rdata[ADDR_W-1:0] : pc_q + ADDR_W'(1);
            // Dropping run ends the program at the next fetch decision.
            if (run) begin
              state_d = S_FETCH;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
          OP_HALT: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default: begin
            error_d = 1'b1;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        endcase
      end
      S_ISSUE: begin
        if (layer_ready) begin
          valid_d = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // layer_done is only honoured here, never in the accept cycle.
        if (layer_done) begin
          if (!desc_q[OUT_BIT] && run) begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else if (desc_q[OUT_BIT] && run && continuous) begin
            pc_d    = start_addr;
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      desc_q      <= '0;
      acc_reset_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      desc_q      <= desc_d;
      acc_reset_q <= acc_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_rd_en          = (state_q == S_FETCH);
  assign mem_addr           = pc_q;
  assign layer_valid        = valid_q;
  assign layer_reset        = desc_q[RST_BIT];
  assign layer_x_offset     = desc_q[XOFF_LSB +: X_OFF_W];
  assign layer_w_offset     = desc_q[WOFF_LSB +: W_OFF_W];
  assign layer_output_layer = desc_q[OUT_BIT];
  assign layer_y_offset     = desc_q[YOFF_LSB +: Y_OFF_W];
  assign layer_x_length     = desc_q[XLEN_LSB +: LEN_W];
  assign layer_y_length     = desc_q[YLEN_LSB +: LEN_W];
  assign layer_act_mask     = desc_q[ACT_LSB +: ACT_W];
  assign acc_reset          = acc_reset_q;
  assign busy               = (state_q != S_IDLE);
  assign done               = done_q;
  assign error              = error_q;

`ifdef LAYER_SEQ_PERF_CNT_EN
  logic [31:0] perf_layers_q, perf_layers_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        start_evt, accept_evt, stall_evt;

  assign start_evt  = (state_q == S_IDLE) && run;
  assign accept_evt = valid_q && layer_ready;
  assign stall_evt  = valid_q && !layer_ready;

  always_comb begin
    perf_layers_d = perf_layers_q;
    perf_stall_d  = perf_stall_q;
    if (start_evt) begin
      perf_layers_d = '0;
      perf_stall_d  = '0;
    end else begin
      if (accept_evt && (perf_layers_q != '1)) perf_layers_d = perf_layers_q + 32'd1;
      if (stall_evt && (perf_stall_q != '1))   perf_stall_d  = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_layers_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_layers_q <= perf_layers_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_layers = perf_layers_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_layer_sequencer
//   Directed bench for layer_sequencer. Expected layer descriptors are
//   queued when the program is loaded and popped as the core accepts them.
//   A posedge monitor logs fetch addresses and counts done / acc_reset /
//   layer_valid cycles; the stimulus compares deltas of those logs.
// ---------------------------------------------------------------------------
module tb_layer_sequencer;

  localparam int INST_W = 67;

  logic              clk = 1'b0;
  logic              rst, run, continuous;
  logic [7:0]        start_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_addr;
  logic [INST_W-1:0] mem_rdata;
  logic              layer_valid, layer_ready;
  logic              layer_reset;
  logic [10:0]       layer_x_offset;
  logic [11:0]       layer_w_offset;
  logic              layer_output_layer;
  logic [10:0]       layer_y_offset;
  logic [11:0]       layer_x_length, layer_y_length;
  logic [3:0]        layer_act_mask;
  logic              layer_done;
  logic              acc_reset, busy, done, error;
`ifdef LAYER_SEQ_PERF_CNT_EN
  logic [31:0]       perf_layers, perf_stall;
`endif

  layer_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .continuous(continuous),
    .start_addr(start_addr), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .layer_valid(layer_valid), .layer_ready(layer_ready),
    .layer_reset(layer_reset), .layer_x_offset(layer_x_offset),
    .layer_w_offset(layer_w_offset), .layer_output_layer(layer_output_layer),
    .layer_y_offset(layer_y_offset), .layer_x_length(layer_x_length),
    .layer_y_length(layer_y_length), .layer_act_mask(layer_act_mask),
    .layer_done(layer_done), .acc_reset(acc_reset), .busy(busy),
    .done(done), .error(error)
`ifdef LAYER_SEQ_PERF_CNT_EN
    , .perf_layers(perf_layers), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Program memory with one-cycle registered read.
  logic [INST_W-1:0] prog [256];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= prog[mem_addr];
  end

  // Monitor: pre-edge values are sampled at the posedge.
  logic [7:0] fetch_log [$];
  int acc_cnt = 0, done_cnt = 0, valid_cnt = 0;
  always @(posedge clk) begin
    if (mem_rd_en === 1'b1) fetch_log.push_back(mem_addr);
    if (acc_reset === 1'b1) acc_cnt <= acc_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (layer_valid === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q [$];
  logic [INST_W-1:0] l0w, l1w, wtmp;
  int fb, db, ab, vb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [INST_W-1:0] mk(input logic [2:0] op, input logic rs,
      input logic [10:0] xo, input logic [11:0] wo, input logic ol,
      input logic [10:0] yo, input logic [11:0] xl, input logic [11:0] yl,
      input logic [3:0] am);
    return {op, rs, xo, wo, ol, yo, xl, yl, am};
  endfunction

  function automatic logic [63:0] obs_desc();
    return {layer_reset, layer_x_offset, layer_w_offset, layer_output_layer,
            layer_y_offset, layer_x_length, layer_y_length, layer_act_mask};
  endfunction

  task automatic push_exp(input logic [INST_W-1:0] w);
    exp_q.push_back(w[63:0]);
  endtask

  // Wait for layer_valid, compare against the scoreboard, optionally hold
  // ready low for 'stall' cycles, then accept. exp_lat < 0 skips latency.
  task automatic expect_issue(input string tag, input int stall, input int exp_lat);
    int n;
    logic [63:0] e;
    layer_ready = (stall == 0);
    @(negedge clk);
    n = 1;
    while (layer_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(layer_valid), 64'(1'b1));
    if (exp_lat >= 0) check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
    for (int i = 0; i < stall; i++) begin
      check($sformatf("%s_stall%0d_desc", tag, i), obs_desc(), e);
      check($sformatf("%s_stall%0d_valid", tag, i), 64'(layer_valid), 64'(1'b1));
      @(negedge clk);
    end
    check({tag, "_desc"}, obs_desc(), e);
    layer_ready = 1'b1;
    @(negedge clk);
    check({tag, "_drop"}, 64'(layer_valid), 64'(1'b0));
    check({tag, "_busy"}, 64'(busy), 64'(1'b1));
  endtask

  task automatic pulse_done(input int wait_cycles);
    repeat (wait_cycles) @(negedge clk);
    layer_done = 1'b1;
    @(negedge clk);
    layer_done = 1'b0;
  endtask

  // Wait (bounded) for the done pulse, then drop run so no restart follows.
  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'(1'b1));
    run = 1'b0;
  endtask

  task automatic snap();
    fb = fetch_log.size();
    db = done_cnt;
    ab = acc_cnt;
    vb = valid_cnt;
  endtask

  task automatic check_fetch(input string tag, input int expv[$]);
    int got = fetch_log.size() - fb;
    check({tag, "_nfetch"}, 64'(got), 64'(expv.size()));
    for (int i = 0; i < expv.size() && i < got; i++)
      check($sformatf("%s_fetch%0d", tag, i), 64'(fetch_log[fb+i]), 64'(expv[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = '0;
    rst = 1'b1; run = 1'b0; continuous = 1'b0; start_addr = 8'd0;
    layer_ready = 1'b1; layer_done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_done", 64'(done), 64'(1'b0));
    check("rst_error", 64'(error), 64'(1'b0));
    check("rst_valid", 64'(layer_valid), 64'(1'b0));
    check("rst_rd_en", 64'(mem_rd_en), 64'(1'b0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_acc", 64'(acc_reset), 64'(1'b0));
    check("rst_desc", obs_desc(), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Two-layer program, single pass
    l0w = mk(3'd1, 1'b1, 11'h123, 12'hABC, 1'b0, 11'h456, 12'h010, 12'h020, 4'h5);
    l1w = mk(3'd1, 1'b0, 11'h7FF, 12'h001, 1'b1, 11'h002, 12'hFFF, 12'h800, 4'hA);
    prog[0] = l0w; prog[1] = l1w;
    push_exp(l0w); push_exp(l1w);
    snap();
    run = 1'b1;
    expect_issue("t1_l0", 0, 3);
    pulse_done(2);
    expect_issue("t1_l1", 0, 2);
    pulse_done(1);
    wait_done("t1");
    repeat (3) @(negedge clk);
    check("t1_busy", 64'(busy), 64'(1'b0));
    check("t1_ndone", 64'(done_cnt - db), 64'(1));
    check_fetch("t1", '{0, 1});

    // Continuous: loops back to start_addr after the output layer
    push_exp(l0w); push_exp(l1w); push_exp(l0w);
    snap();
    continuous = 1'b1; run = 1'b1;
    expect_issue("t2_l0", 0, 3);
    pulse_done(0);
    expect_issue("t2_l1", 0, 2);
    pulse_done(0);
    expect_issue("t2_l0b", 0, 2);
    run = 1'b0;
    pulse_done(1);
    wait_done("t2");
    continuous = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_busy", 64'(busy), 64'(1'b0));
    check("t2_ndone", 64'(done_cnt - db), 64'(1));
    check_fetch("t2", '{0, 1, 0});

    // RESET, JUMP, HALT
    prog[0] = mk(3'd2, 1'b0, 11'd0, 12'd0, 1'b0, 11'd0, 12'd0, 12'd0, 4'd0);
    wtmp = '0; wtmp[66:64] = 3'd3; wtmp[7:0] = 8'd5;
    prog[1] = wtmp;
    prog[5] = '0;
    snap();
    run = 1'b1;
    wait_done("t3");
    repeat (3) @(negedge clk);
    check("t3_nacc", 64'(acc_cnt - ab), 64'(1));
    check("t3_nvalid", 64'(valid_cnt - vb), 64'(0));
    check("t3_ndone", 64'(done_cnt - db), 64'(1));
    check("t3_error", 64'(error), 64'(1'b0));
    check_fetch("t3", '{0, 1, 5});

    // Ready held low for 4 cycles
    prog[0] = l1w;
    push_exp(l1w);
    run = 1'b1;
    expect_issue("t4", 4, -1);
`ifdef LAYER_SEQ_PERF_CNT_EN
    check("t4_perf_stall", 64'(perf_stall), 64'(4));
    check("t4_perf_layers", 64'(perf_layers), 64'(1));
`endif
    pulse_done(2);
    wait_done("t4");
    repeat (2) @(negedge clk);

    // Illegal opcode, then restart clears the error
    prog[0] = mk(3'd6, 1'b0, 11'd0, 12'd0, 1'b0, 11'd0, 12'd0, 12'd0, 4'd0);
    run = 1'b1;
    wait_done("t5");
    check("t5_error_set", 64'(error), 64'(1'b1));
    repeat (3) @(negedge clk);
    check("t5_error_sticky", 64'(error), 64'(1'b1));
    prog[0] = '0;
    run = 1'b1;
    @(negedge clk);
    check("t5_error_clr", 64'(error), 64'(1'b0));
    wait_done("t5b");
    check("t5_error_after", 64'(error), 64'(1'b0));
    repeat (2) @(negedge clk);

    // Reset while BUSY, then wrap from address 255
    prog[0] = l0w;
    push_exp(l0w);
    run = 1'b1;
    expect_issue("t6_pre", 0, 3);
    snap();
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    check("t6_busy", 64'(busy), 64'(1'b0));
    check("t6_valid", 64'(layer_valid), 64'(1'b0));
    check("t6_done", 64'(done), 64'(1'b0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_ndone", 64'(done_cnt - db), 64'(0));
    start_addr = 8'd255;
    prog[255] = l0w; prog[0] = l1w;
    push_exp(l0w); push_exp(l1w);
    snap();
    run = 1'b1;
    expect_issue("t6_a", 0, 3);
    pulse_done(1);
    expect_issue("t6_b", 0, 2);
    pulse_done(1);
    wait_done("t6");
    repeat (2) @(negedge clk);
    check_fetch("t6", '{255, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
